instr_mem_param: RTL and testbench
==================================

Name: instr_mem_param

Overview:
Parametrised instruction memory for the RISC-V cores, single- or multi-cycle.
- Generalised in width and depth.
- Adds a runtime program-load port, so test programs are written in rather than hard-coded at reset.
- Self-clears after reset with a sequential fill engine.
- Uses a registered fetch port with a valid strobe and fault flags for misaligned and out-of-range PCs.
- Sits between the PC/fetch stage and the decoder; the loader port is driven by the bench or a boot loader.

Parameters:
- XLEN, 32, instruction word width in bits.
- ADDR_W, 32, width of the byte addresses read_address and prog_addr.
- DEPTH, 64, number of words; must be a power of two, at least 2.
- FILL_WORD, 32'h00000013, word written to every location during clear; also returned on any fault (NOP: addi x0,x0,0).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- prog_we, input, 1, program-load write enable.
- prog_addr, input, ADDR_W, program-load byte address.
- prog_data, input, XLEN, program-load word.
- fetch_req, input, 1, fetch request.
- read_address, input, ADDR_W, fetch byte address (the PC).
- instruction_out, output, XLEN, fetched word, registered.
- instr_valid, output, 1, one-cycle strobe: instruction_out and the fault flags are valid.
- misaligned, output, 1, fault: read_address[1:0] != 0.
- out_of_range, output, 1, fault: word index >= DEPTH.
- busy, output, 1, high while clearing; fetch and prog requests are ignored.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high, sampled on the clk rising edge.
- Word index is address >> 2.
  - In range means the index is < DEPTH; the upper address bits are checked, not truncated.
- FSM states are CLEAR and READY.
  - reset=1 forces CLEAR and sets the clear counter to 0. This applies from any state, including mid-clear.
- CLEAR:
  - Each cycle writes FILL_WORD to mem[counter], then increments the counter.
  - When counter == DEPTH-1 has been written, the next state is READY.
  - Clearing takes exactly DEPTH cycles after reset deasserts.
  - busy=1 throughout.
  - fetch_req and prog_we are ignored (no write, no strobe).
- READY:
  - busy=0.
  - Stays in READY until reset.
- Reset values, registered in the reset cycle:
  - instruction_out = FILL_WORD.
  - instr_valid = 0, misaligned = 0, out_of_range = 0.
  - busy = 1.
- Fetch (READY only):
  - fetch_req sampled high at edge N gives, after edge N+1:
    - instr_valid=1 for one cycle.
    - instruction_out = mem[index] when there is no fault.
  - Latency is 1 cycle. Back-to-back requests give back-to-back strobes (throughput 1/cycle).
  - Without a request, instr_valid=0 and instruction_out holds its last value.
- Fault priority is misaligned first, then out-of-range.
  - On either fault: instruction_out = FILL_WORD, the matching flag is 1, instr_valid=1.
  - Both flags may be 1 together.
  - Flags are only meaningful when instr_valid=1 and are cleared on cycles without a strobe.
- Program load (READY only):
  - When prog_we=1, prog_data is written to mem[prog_addr>>2] at the edge.
  - The write is silently dropped if prog_addr[1:0] != 0 or the index is >= DEPTH. No other side effects.
- Simultaneous fetch and write to the same index in one cycle:
  - Read-before-write: the fetch returns the old word.
  - The new word is visible to the next fetch.
- Fetch request held during the last CLEAR cycle: ignored. The first serviced request is the one sampled while busy=0.
- Memory contents are undefined before the first reset. After clear, every word equals FILL_WORD.
- No combinational path from inputs to outputs.
- $display is not used in synthesizable code.

Test Plan:
1. Reset for 1 cycle, then wait: busy=1 for exactly 64 cycles after reset deasserts, then 0. Then fetch addresses 0x00, 0x7C, 0xFC → each returns 0x00000013 one cycle later, with instr_valid a 1-cycle pulse and no fault flags.
2. Program-then-fetch:
   - Load mem[1]=0x00500193, mem[2]=0x00A00213, mem[4]=0x004181B3.
   - Fetch 0x04, 0x08, 0x10 back-to-back → the three words on three consecutive strobes.
3. Faults:
   - Fetch 0x06 → misaligned=1, instruction_out=0x00000013.
   - Fetch 0x100 → out_of_range=1.
   - Fetch 0x102 → both flags=1.
   - prog_we to 0x100 and to 0x0A → memory unchanged (verified by fetching 0x08 and 0x00).
4. Read/write collision:
   - mem[3]=0x01400313; same cycle, fetch 0x0C and write 0x00628233 to 0x0C → returns 0x01400313.
   - Next fetch of 0x0C → 0x00628233.
5. Reset mid-operation:
   - Reset during clear (cycle 20) → busy stays 1 for 64 cycles from the new deassert.
   - Reset in READY after programming mem[1] → after re-clear, fetch 0x04 returns 0x00000013. instr_valid=0 during the reset cycle and during clear, even with fetch_req held high.
6. Parameter sweep: DEPTH=16, XLEN=32 → busy lasts 16 cycles; fetch 0x40 flags out_of_range; fetch 0x3C is in range.

Source files
------------

// File: rtl/instr_mem_param.sv
// instr_mem_param: parametrised instruction memory for the RISC-V cores.
//   After every reset a fill engine writes FILL_WORD into all DEPTH words,
//   one per cycle, with busy high. Once READY, the memory serves registered
//   fetches, one per cycle, and accepts program-load writes.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   prog_we/addr/data   : program-load write (byte address, word data)
//   fetch_req           : fetch request at byte address read_address (PC)
//   instruction_out     : registered fetched word (FILL_WORD on any fault)
//   instr_valid         : one-cycle strobe qualifying instruction_out and flags
//   misaligned          : read_address[1:0] != 0
//   out_of_range        : word index >= DEPTH (full upper address checked)
//   busy                : high while clearing; requests are ignored
module instr_mem_param #(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] FILL_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] read_address,
  output logic [XLEN-1:0]   instruction_out,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              busy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  logic [XLEN-1:0]  mem [DEPTH];

  // Address decode. Bits above the index field must be zero to be in range,
  // so large addresses fault instead of aliasing onto low words.
  logic             f_mis, f_oor, p_ok;
  logic [IDX_W-1:0] f_idx, p_idx;

  assign f_mis = (read_address[1:0] != 2'b00);
  assign f_oor = |(read_address >> (IDX_W + 2));
  assign f_idx = read_address[IDX_W+1:2];
  assign p_idx = prog_addr[IDX_W+1:2];
  assign p_ok  = (prog_addr[1:0] == 2'b00) && !(|(prog_addr >> (IDX_W + 2)));

  // Next-state: the clear counter walks 0..DEPTH-1, then READY until reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  // Single write port shared by the fill engine and the loader.
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [XLEN-1:0]  mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = p_idx;
    mem_wdata = prog_data;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = FILL_WORD;
      end else begin
        mem_we = prog_we && p_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch reads mem with the pre-edge contents, so a same-cycle write to the
  // same word is seen only by the next fetch (read-before-write).
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= CLEAR;
      cnt             <= '0;
      instruction_out <= FILL_WORD;
      instr_valid     <= 1'b0;
      misaligned      <= 1'b0;
      out_of_range    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == READY && fetch_req) begin
        instr_valid     <= 1'b1;
        misaligned      <= f_mis;
        out_of_range    <= f_oor;
        instruction_out <= (f_mis || f_oor) ? FILL_WORD : mem[f_idx];
      end else begin
        instr_valid  <= 1'b0;
        misaligned   <= 1'b0;
        out_of_range <= 1'b0;
      end
    end
  end

  assign busy = (state == CLEAR);
endmodule

// File: tb/tb_instr_mem_param.sv
// Directed bench for instr_mem_param: a DEPTH=64 instance plus a DEPTH=16
// instance sharing all inputs.
module tb_instr_mem_param;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        fetch_req = 1'b0;
  logic [31:0] read_address = '0;

  logic [31:0] instruction_out, instruction_out2;
  logic        instr_valid, misaligned, out_of_range, busy;
  logic        instr_valid2, misaligned2, out_of_range2, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_param #(.XLEN(32), .ADDR_W(32), .DEPTH(64), .FILL_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_req(fetch_req), .read_address(read_address),
    .instruction_out(instruction_out), .instr_valid(instr_valid),
    .misaligned(misaligned), .out_of_range(out_of_range), .busy(busy));

  instr_mem_param #(.XLEN(32), .ADDR_W(32), .DEPTH(16), .FILL_WORD(NOP)) dut16 (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_req(fetch_req), .read_address(read_address),
    .instruction_out(instruction_out2), .instr_valid(instr_valid2),
    .misaligned(misaligned2), .out_of_range(out_of_range2), .busy(busy2));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; read_address = a;
    tick();
    fetch_req = 1'b0;
  endtask

  // One reset edge, then count busy cycles of both instances (bounded).
  task automatic test_reset();
    int n64, n16;
    reset = 1'b1;
    tick();
    checks++;
    if (instruction_out !== NOP || instr_valid !== 1'b0 || misaligned !== 1'b0 ||
        out_of_range !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: out=%h v=%b m=%b o=%b busy=%b, want %h 0 0 0 1",
               instruction_out, instr_valid, misaligned, out_of_range, busy, NOP);
    end
    reset = 1'b0;
    n64 = 0; n16 = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n64++;
      if (busy2) n16++;
      tick();
    end
    checks++;
    if (n64 !== 64) begin
      failures++;
      $display("FAIL busy_len64: got %0d cycles, want 64", n64);
    end
    checks++;
    if (n16 !== 16) begin
      failures++;
      $display("FAIL busy_len16: got %0d cycles, want 16", n16);
    end
  endtask

  task automatic test_clear_contents();
    logic [31:0] addrs [3] = '{32'h00, 32'h7C, 32'hFC};
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i]);
      checks++;
      if (instruction_out !== NOP || instr_valid !== 1'b1 || misaligned !== 1'b0 ||
          out_of_range !== 1'b0) begin
        failures++;
        $display("FAIL clear_fetch[%h]: out=%h v=%b m=%b o=%b, want %h 1 0 0",
                 addrs[i], instruction_out, instr_valid, misaligned, out_of_range, NOP);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL valid_pulse[%h]: valid=%b, want 0", addrs[i], instr_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h04, 32'h08, 32'h10};
    logic [31:0] words [3] = '{32'h00500193, 32'h00A00213, 32'h004181B3};
    for (int i = 0; i < 3; i++) prog(addrs[i], words[i]);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_address = addrs[i];
      tick();
      checks++;
      if (instruction_out !== words[i] || instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d]: out=%h v=%b, want %h 1",
                 i, instruction_out, instr_valid, words[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instruction_out !== 32'h004181B3) begin
      failures++;
      $display("FAIL hold_idle: out=%h v=%b, want 004181b3 0", instruction_out, instr_valid);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3] = '{32'h06, 32'h100, 32'h102};
    logic        wm [3] = '{1'b1, 1'b0, 1'b1};
    logic        wo [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i]);
      checks++;
      if (instruction_out !== NOP || instr_valid !== 1'b1 ||
          misaligned !== wm[i] || out_of_range !== wo[i]) begin
        failures++;
        $display("FAIL fault[%h]: out=%h v=%b m=%b o=%b, want %h 1 %b %b", addrs[i],
                 instruction_out, instr_valid, misaligned, out_of_range, NOP, wm[i], wo[i]);
      end
    end
    tick();
    checks++;
    if (misaligned !== 1'b0 || out_of_range !== 1'b0) begin
      failures++;
      $display("FAIL flags_clear: m=%b o=%b, want 0 0", misaligned, out_of_range);
    end
    // Dropped writes: 0x100 would alias to word 0, 0x0A to word 2.
    prog(32'h100, 32'hDEADBEEF);
    prog(32'h0A, 32'hCAFEF00D);
    fetch(32'h08);
    checks++;
    if (instruction_out !== 32'h00A00213) begin
      failures++;
      $display("FAIL drop_misaligned_wr: got %h, want 00a00213", instruction_out);
    end
    fetch(32'h00);
    checks++;
    if (instruction_out !== NOP) begin
      failures++;
      $display("FAIL drop_oor_wr: got %h, want %h", instruction_out, NOP);
    end
  endtask

  task automatic test_collision();
    prog(32'h0C, 32'h01400313);
    fetch_req = 1'b1; read_address = 32'h0C;
    prog_we = 1'b1; prog_addr = 32'h0C; prog_data = 32'h00628233;
    tick();
    fetch_req = 1'b0; prog_we = 1'b0;
    checks++;
    if (instruction_out !== 32'h01400313 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL rbw_old: out=%h v=%b, want 01400313 1", instruction_out, instr_valid);
    end
    fetch(32'h0C);
    checks++;
    if (instruction_out !== 32'h00628233) begin
      failures++;
      $display("FAIL rbw_new: got %h, want 00628233", instruction_out);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (20) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL busy_after_mid_reset: got %0d cycles, want 64", n);
    end
  endtask

  task automatic test_reset_ready();
    int n, bad_v;
    prog(32'h04, 32'h00500193);
    fetch(32'h04);
    checks++;
    if (instruction_out !== 32'h00500193) begin
      failures++;
      $display("FAIL pre_reset_fetch: got %h, want 00500193", instruction_out);
    end
    // Reset with a faulting fetch held high: outputs still take reset values.
    fetch_req = 1'b1; read_address = 32'h102;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (instruction_out !== NOP || instr_valid !== 1'b0 || misaligned !== 1'b0 ||
        out_of_range !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: out=%h v=%b m=%b o=%b busy=%b, want %h 0 0 0 1",
               instruction_out, instr_valid, misaligned, out_of_range, busy, NOP);
    end
    read_address = 32'h04;
    n = 0; bad_v = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n++;
      if (instr_valid !== 1'b0) bad_v++;
      tick();
    end
    checks++;
    if (n !== 64 || bad_v !== 0) begin
      failures++;
      $display("FAIL clear_ignores_fetch: busy=%0d valid_hits=%0d, want 64 0", n, bad_v);
    end
    // Request held through the last clear cycle must not produce a strobe.
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL last_clear_fetch: valid=%b, want 0", instr_valid);
    end
    tick();
    fetch_req = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instruction_out !== NOP) begin
      failures++;
      $display("FAIL refetch_after_clear: out=%h v=%b, want %h 1", instruction_out, instr_valid, NOP);
    end
  endtask

  task automatic test_depth16();
    fetch(32'h40);
    checks++;
    if (out_of_range2 !== 1'b1 || instruction_out2 !== NOP || instr_valid2 !== 1'b1) begin
      failures++;
      $display("FAIL d16_oor: o=%b out=%h v=%b, want 1 %h 1", out_of_range2, instruction_out2, instr_valid2, NOP);
    end
    checks++;
    if (out_of_range !== 1'b0) begin
      failures++;
      $display("FAIL d64_in_range_40: o=%b, want 0", out_of_range);
    end
    fetch(32'h3C);
    checks++;
    if (out_of_range2 !== 1'b0 || misaligned2 !== 1'b0 || instruction_out2 !== NOP ||
        instr_valid2 !== 1'b1) begin
      failures++;
      $display("FAIL d16_in_range: o=%b m=%b out=%h v=%b, want 0 0 %h 1",
               out_of_range2, misaligned2, instruction_out2, instr_valid2, NOP);
    end
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_back_to_back();
    test_faults();
    test_collision();
    test_reset_mid_clear();
    test_reset_ready();
    test_depth16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
